// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between the datapath and muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       control;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             o;

  modport master (
    output start, control, in1, in2, flush, hi_we, lo_we,
    input  busy, done, hi, lo, o
  );

  modport slave (
    input  start, control, in1, in2, flush, hi_we, lo_we,
    output busy, done, hi, lo, o
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative mul/div owning HI/LO; signed codes need MULDIV_SIGNED_EN
// Without MULDIV_SIGNED_EN, codes 1110/1111 run as unsigned with identical latency.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic                 is_div, dz;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 o_q, busy_q, done_q;

  logic                 can_start, accept, op_div, div_zero;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   fixed;

  assign can_start = (state_q == IDLE) || (state_q == DONE);
  assign accept    = can_start && bus.start && (bus.control[3:2] == 2'b11) && !bus.flush;
  assign op_div    = bus.control[0];
  assign div_zero  = op_div && (bus.in2 == '0);

`ifdef MULDIV_SIGNED_EN
  logic neg_a, neg_b, neg_x_q, neg_r_q;
  assign neg_a = bus.control[1] & bus.in1[WIDTH-1];
  assign neg_b = bus.control[1] & bus.in2[WIDTH-1];
  assign mag_a = neg_a ? -bus.in1 : bus.in1;
  assign mag_b = neg_b ? -bus.in2 : bus.in2;
`else
  assign mag_a = bus.in1;
  assign mag_b = bus.in2;
`endif

  // acc holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opb};

  always_comb begin
    fixed = acc;
`ifdef MULDIV_SIGNED_EN
    if (!is_div) begin
      if (neg_x_q) fixed = -acc;
    end else begin
      if (neg_x_q) fixed[WIDTH-1:0]       = -acc[WIDTH-1:0];
      if (neg_r_q) fixed[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) state_d = div_zero ? FIX : RUN;
      end
      RUN: begin
        if (bus.flush)          state_d = IDLE;
        else if (count == '0)   state_d = FIX;
      end
      FIX:     state_d = bus.flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count   <= '0;
      acc     <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      dz      <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_x_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN) || (state_d == FIX);
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.start) begin
            if (bus.hi_we) hi_q <= bus.in1;
            if (bus.lo_we) lo_q <= bus.in1;
          end
        end
        RUN: begin
          if (count != '0) count <= count - 1'b1;
          if (is_div)
            acc <= {div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0],
                    acc[WIDTH-2:0], ~div_diff[WIDTH]};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX:  acc <= fixed;
        DONE: begin
          hi_q   <= acc[2*WIDTH-1:WIDTH];
          lo_q   <= acc[WIDTH-1:0];
          o_q    <= dz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
      // a start taken in the DONE cycle reloads acc after DONE has read it
      if (accept) begin
        is_div <= op_div;
        dz     <= div_zero;
        count  <= CW'(ITER - 1);
        opb    <= op_div ? mag_b : mag_a;
        acc    <= div_zero ? '0 : {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
`ifdef MULDIV_SIGNED_EN
        neg_x_q <= (neg_a ^ neg_b) & ~div_zero;
        neg_r_q <= neg_a & op_div & ~div_zero;
`endif
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.o    = o_q;
endmodule
